// File: rtl/eth_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : eth_tx_arbiter
// Description : Round-robin GMII TX arbiter for the ARP/ICMP/UDP generators,
//               with per-frame grant handshake, owner data mux and enforced
//               inter-frame gap. Optional BUSY watchdog: ETH_TX_WATCHDOG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module eth_tx_arbiter #(
    parameter int unsigned IFG_CYCLES       = 12,
    parameter logic [23:0] MAX_FRAME_CYCLES = 24'd2000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       arp_req,
    input  logic       icmp_req,
    input  logic       udp_req,
    output logic       arp_gnt,
    output logic       icmp_gnt,
    output logic       udp_gnt,
    input  logic       arp_done,
    input  logic       icmp_done,
    input  logic       udp_done,
    input  logic       arp_gmii_tx_en,
    input  logic       icmp_gmii_tx_en,
    input  logic       udp_gmii_tx_en,
    input  logic [7:0] arp_gmii_txd,
    input  logic [7:0] icmp_gmii_txd,
    input  logic [7:0] udp_gmii_txd,
    output logic       gmii_tx_en,
    output logic [7:0] gmii_txd,
    output logic       tx_busy,
    output logic [1:0] owner,
    output logic       timeout
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_BUSY  = 2'd2,
        S_IFG   = 2'd3
    } state_t;

    localparam logic [1:0] C_ARP      = 2'd0;
    localparam logic [1:0] C_ICMP     = 2'd1;
    localparam logic [1:0] C_UDP      = 2'd2;
    localparam logic [7:0] C_IFG_LAST = 8'(IFG_CYCLES - 1);

    state_t     state_q,   state_d;
    logic [1:0] owner_q,   owner_d;
    logic [7:0] ifg_cnt_q, ifg_cnt_d;
    logic [2:0] gnt_q,     gnt_d;
    logic       tx_en_q,   tx_en_d;
    logic [7:0] txd_q,     txd_d;

    logic [2:0] w_req;
    logic       w_pick_valid;
    logic [1:0] w_pick;
    logic       w_own_done;
    logic       w_own_en;
    logic [7:0] w_own_txd;
    logic       w_timeout;

    assign w_req = {udp_req, icmp_req, arp_req};

    // Search starts one past the last owner; descending loop lets the nearest win.
    always_comb begin
        w_pick_valid = 1'b0;
        w_pick       = owner_q;
        for (int k = 3; k >= 1; k--) begin
            if (w_req[(int'(owner_q) + k) % 3]) begin
                w_pick_valid = 1'b1;
                w_pick       = 2'((int'(owner_q) + k) % 3);
            end
        end
    end

    always_comb begin
        case (owner_q)
            C_ARP: begin
                w_own_done = arp_done;
                w_own_en   = arp_gmii_tx_en;
                w_own_txd  = arp_gmii_txd;
            end
            C_ICMP: begin
                w_own_done = icmp_done;
                w_own_en   = icmp_gmii_tx_en;
                w_own_txd  = icmp_gmii_txd;
            end
            default: begin
                w_own_done = udp_done;
                w_own_en   = udp_gmii_tx_en;
                w_own_txd  = udp_gmii_txd;
            end
        endcase
    end

`ifdef ETH_TX_WATCHDOG_EN
    logic [23:0] wd_cnt_q, wd_cnt_d;

    assign w_timeout = (state_q == S_BUSY) && !w_own_done &&
                       (wd_cnt_q == MAX_FRAME_CYCLES - 24'd1);

    always_comb begin
        wd_cnt_d = wd_cnt_q;
        if (state_q == S_GRANT) begin
            wd_cnt_d = 24'd0;
        end else if (state_q == S_BUSY) begin
            wd_cnt_d = wd_cnt_q + 24'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt_q <= 24'd0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
        end
    end
`else
    logic unused_wd_cfg;
    assign unused_wd_cfg = ^MAX_FRAME_CYCLES;
    assign w_timeout     = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ifg_cnt_d = ifg_cnt_q;
        gnt_d     = 3'b000;
        tx_en_d   = 1'b0;
        txd_d     = 8'd0;
        case (state_q)
            S_IDLE: begin
                if (w_pick_valid) begin
                    owner_d = w_pick;
                    gnt_d   = 3'b001 << w_pick;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                tx_en_d = w_own_en;
                txd_d   = w_own_txd;
                state_d = S_BUSY;
            end
            S_BUSY: begin
                // An aborted frame must not leak its last byte into the gap.
                if (!w_timeout) begin
                    tx_en_d = w_own_en;
                    txd_d   = w_own_txd;
                end
                if (w_own_done || w_timeout) begin
                    ifg_cnt_d = 8'd0;
                    state_d   = S_IFG;
                end
            end
            default: begin
                if (ifg_cnt_q == C_IFG_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    ifg_cnt_d = ifg_cnt_q + 8'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            owner_q   <= C_UDP;
            ifg_cnt_q <= 8'd0;
            gnt_q     <= 3'b000;
            tx_en_q   <= 1'b0;
            txd_q     <= 8'd0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            ifg_cnt_q <= ifg_cnt_d;
            gnt_q     <= gnt_d;
            tx_en_q   <= tx_en_d;
            txd_q     <= txd_d;
        end
    end

    assign arp_gnt    = gnt_q[0];
    assign icmp_gnt   = gnt_q[1];
    assign udp_gnt    = gnt_q[2];
    assign gmii_tx_en = tx_en_q;
    assign gmii_txd   = txd_q;
    assign tx_busy    = (state_q != S_IDLE);
    assign owner      = owner_q;
    assign timeout    = w_timeout;

endmodule
`default_nettype wire

// File: tb/tb_eth_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_eth_tx_arbiter
// Description : Self-checking bench for eth_tx_arbiter with a time-based
//               behavioural model and reactive randomized requesters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eth_tx_arbiter;

    localparam int IFG = 12;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       arp_gnt, icmp_gnt, udp_gnt;
    logic       gmii_tx_en;
    logic [7:0] gmii_txd;
    logic       tx_busy;
    logic [1:0] owner;
    logic       timeout;

    // Requester-side stimulus, index 0 ARP, 1 ICMP, 2 UDP
    bit         g_req  [3];
    bit         g_act  [3];
    int         g_len  [3];
    bit         g_en   [3];
    logic [7:0] g_txd  [3];
    bit         g_done [3];

    eth_tx_arbiter #(.IFG_CYCLES(IFG)) dut (
        .clk(clk), .rst(rst),
        .arp_req(g_req[0]), .icmp_req(g_req[1]), .udp_req(g_req[2]),
        .arp_gnt(arp_gnt), .icmp_gnt(icmp_gnt), .udp_gnt(udp_gnt),
        .arp_done(g_done[0]), .icmp_done(g_done[1]), .udp_done(g_done[2]),
        .arp_gmii_tx_en(g_en[0]), .icmp_gmii_tx_en(g_en[1]), .udp_gmii_tx_en(g_en[2]),
        .arp_gmii_txd(g_txd[0]), .icmp_gmii_txd(g_txd[1]), .udp_gmii_txd(g_txd[2]),
        .gmii_tx_en(gmii_tx_en), .gmii_txd(gmii_txd),
        .tx_busy(tx_busy), .owner(owner), .timeout(timeout)
    );

    always #4 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Stimulus knobs
    bit   rst_next      = 1'b1;
    bit   noise         = 1'b0;
    int   raise_pct     = 0;
    int   withdraw_pmil = 0;
    int   fixed_len     = 0;
    int   rst_pmil      = 0;
    logic [2:0] raise_mask = 3'b000;

    // Model: owner, whether a frame is open, its grant cycle, first idle cycle
    int   m_owner;
    bit   m_in_frame;
    int   m_gnt;
    int   m_free;
    bit   exp_valid = 1'b0;
    logic [2:0] exp_gnt;
    logic       exp_en;
    logic [7:0] exp_txd;
    logic       exp_busy;
    logic [1:0] exp_owner;

    int gnt_cyc_q[$];
    int gnt_own_q[$];
    int done_cyc_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s cycle=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_owner    = 2;
        m_in_frame = 1'b0;
        m_gnt      = 0;
        m_free     = cyc + 1;
        exp_gnt    = 3'b000;
        exp_en     = 1'b0;
        exp_txd    = 8'd0;
        exp_busy   = 1'b0;
        exp_owner  = 2'b10;
    endtask

    // One clock cycle: compare, drive this cycle's inputs, predict next cycle.
    task automatic step();
        logic [2:0] gnt_now;
        bit         rst_now;
        bit         found;
        @(negedge clk);
        cyc++;
        gnt_now = {udp_gnt, icmp_gnt, arp_gnt};
        if (exp_valid) begin
            chk("gnt",        {29'd0, gnt_now},    {29'd0, exp_gnt});
            chk("gmii_tx_en", {31'd0, gmii_tx_en}, {31'd0, exp_en});
            chk("gmii_txd",   {24'd0, gmii_txd},   {24'd0, exp_txd});
            chk("tx_busy",    {31'd0, tx_busy},    {31'd0, exp_busy});
            chk("owner",      {30'd0, owner},      {30'd0, exp_owner});
            chk("timeout",    {31'd0, timeout},    32'd0);
            for (int g = 0; g < 3; g++) begin
                if (gnt_now[g]) begin
                    gnt_cyc_q.push_back(cyc);
                    gnt_own_q.push_back(g);
                end
            end
        end

        rst_now = rst_next || ((rst_pmil > 0) && ($urandom % 1000 < rst_pmil));
        rst     = rst_now;

        for (int g = 0; g < 3; g++) begin
            g_done[g] = 1'b0;
            g_en[g]   = 1'b0;
            g_txd[g]  = 8'h00;
            if (rst_now) begin
                g_act[g] = 1'b0;
            end else if (g_act[g]) begin
                g_en[g]  = 1'b1;
                g_txd[g] = 8'($urandom);
                g_len[g]--;
                if (g_len[g] == 0) begin
                    g_done[g] = 1'b1;
                    g_act[g]  = 1'b0;
                    done_cyc_q.push_back(cyc);
                end
            end else if (noise) begin
                // Idle generators chatter; the arbiter must ignore them.
                if ($urandom % 4 == 0) begin
                    g_en[g]  = 1'b1;
                    g_txd[g] = ($urandom % 2 == 0) ? 8'hAA : 8'($urandom);
                end
                if ($urandom % 10 == 0) g_done[g] = 1'b1;
            end

            if (gnt_now[g]) begin
                g_req[g] = 1'b0;
                if (!rst_now) begin
                    g_act[g] = 1'b1;
                    g_len[g] = (fixed_len > 0) ? fixed_len : int'($urandom_range(1, 24));
                end
            end else if (!g_req[g] && !g_act[g]) begin
                if (raise_mask[g] || (int'($urandom % 100) < raise_pct)) g_req[g] = 1'b1;
            end else if (g_req[g] && (int'($urandom % 1000) < withdraw_pmil)) begin
                g_req[g] = 1'b0;
            end
        end
        raise_mask = 3'b000;

        if (rst_now) begin
            model_reset();
        end else begin
            exp_gnt = 3'b000;
            exp_en  = 1'b0;
            exp_txd = 8'd0;
            if (m_in_frame) begin
                exp_en  = g_en[m_owner];
                exp_txd = g_txd[m_owner];
            end
            if (m_in_frame && cyc > m_gnt && g_done[m_owner]) begin
                m_in_frame = 1'b0;
                m_free     = cyc + IFG + 1;
            end else if (!m_in_frame && cyc >= m_free) begin
                found = 1'b0;
                for (int k = 1; k <= 3; k++) begin
                    if (!found && g_req[(m_owner + k) % 3]) begin
                        found      = 1'b1;
                        m_owner    = (m_owner + k) % 3;
                        m_in_frame = 1'b1;
                        m_gnt      = cyc + 1;
                        exp_gnt    = 3'(1 << m_owner);
                    end
                end
            end
            exp_busy  = m_in_frame || (cyc + 1 < m_free);
            exp_owner = 2'(m_owner);
        end
        exp_valid = 1'b1;
    endtask

    initial begin
        int n;
        for (int g = 0; g < 3; g++) begin
            g_req[g] = 1'b0; g_act[g] = 1'b0; g_len[g] = 0;
            g_en[g] = 1'b0; g_txd[g] = 8'h00; g_done[g] = 1'b0;
        end

        // Reset and literal reset-state checks
        repeat (3) step();
        rst_next = 1'b0;
        step();
        chk("rst_gnt",   {29'd0, udp_gnt, icmp_gnt, arp_gnt}, 32'd0);
        chk("rst_tx_en", {31'd0, gmii_tx_en}, 32'd0);
        chk("rst_txd",   {24'd0, gmii_txd},   32'd0);
        chk("rst_busy",  {31'd0, tx_busy},    32'd0);
        chk("rst_owner", {30'd0, owner},      32'd2);

        // All three request together: ARP, ICMP, UDP, each 14 cycles after done
        gnt_cyc_q.delete(); gnt_own_q.delete(); done_cyc_q.delete();
        fixed_len  = 64;
        raise_mask = 3'b111;
        n = 0;
        while (n < 800 && !(gnt_own_q.size() >= 3 && done_cyc_q.size() >= 3)) begin
            step();
            n++;
        end
        chk("three_frames_done", (n < 800) ? 32'd1 : 32'd0, 32'd1);
        repeat (20) step();
        if (gnt_own_q.size() >= 3 && done_cyc_q.size() >= 2) begin
            chk("order_first",  32'(gnt_own_q[0]), 32'd0);
            chk("order_second", 32'(gnt_own_q[1]), 32'd1);
            chk("order_third",  32'(gnt_own_q[2]), 32'd2);
            chk("done_to_gnt_1", 32'(gnt_cyc_q[1] - done_cyc_q[0]), 32'd14);
            chk("done_to_gnt_2", 32'(gnt_cyc_q[2] - done_cyc_q[1]), 32'd14);
        end

        // Reset mid ICMP frame with ARP pending; ARP then wins normally
        gnt_own_q.delete(); gnt_cyc_q.delete();
        fixed_len  = 30;
        raise_mask = 3'b010;
        n = 0;
        while (n < 60 && gnt_own_q.size() == 0) begin
            step();
            n++;
        end
        chk("icmp_granted", (gnt_own_q.size() > 0) ? 32'(gnt_own_q[0]) : 32'd99, 32'd1);
        repeat (4) step();
        raise_mask = 3'b001;
        repeat (2) step();
        chk("mid_frame_tx_en", {31'd0, gmii_tx_en}, 32'd1);
        rst_next = 1'b1;
        step();
        rst_next = 1'b0;
        step();
        chk("mrst_tx_en", {31'd0, gmii_tx_en}, 32'd0);
        chk("mrst_txd",   {24'd0, gmii_txd},   32'd0);
        chk("mrst_busy",  {31'd0, tx_busy},    32'd0);
        chk("mrst_owner", {30'd0, owner},      32'd2);
        gnt_own_q.delete(); gnt_cyc_q.delete();
        n = 0;
        while (n < 10 && gnt_own_q.size() == 0) begin
            step();
            n++;
        end
        chk("post_rst_gnt", (gnt_own_q.size() > 0) ? 32'(gnt_own_q[0]) : 32'd99, 32'd0);
        repeat (60) step();

        // Randomized traffic with chatter, withdrawals and occasional resets
        fixed_len     = 0;
        noise         = 1'b1;
        raise_pct     = 8;
        withdraw_pmil = 20;
        rst_pmil      = 1;
        repeat (6000) step();
        rst_pmil  = 0;
        raise_pct = 0;
        repeat (100) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
